// File: rtl/vend_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// vend_dispense_ctrl
//
// Downstream stage of the vending FSM. Vend strobes and change codes are
// captured every clock into saturating pending counters (pend_b bottles,
// pend_c 5 rs coins). A small FSM drains them onto the mechanical actuators:
// the bottle motor, confirmed by the drop sensor, and the change solenoid.
// A bottle that never reaches the drop sensor latches a sticky fault.
//
// Optional feature (macro DISPENSE_TALLY_EN): adds bottle_cnt / coin_cnt
// tallies of confirmed bottles and paid coins, cleared by reset only.
//
// Ports:
//   clk         in   system clock, all state on rising edge
//   rst_n       in   asynchronous active-low reset
//   vend_i      in   one-cycle dispense-one-bottle strobe
//   change_i    in   [1:0] change code: 00 none, 01 one coin, 10 two coins,
//                    11 invalid (dropped, flagged on overflow)
//   drop_sense  in   bottle-drop sensor, synchronous to clk
//   fault_clr   in   fault acknowledge pulse, only acted on in FAULT
//   motor_on    out  bottle motor drive
//   coin_sol    out  change solenoid drive
//   busy        out  work pending or in progress
//   fault       out  sticky jam indication
//   overflow    out  one-cycle pulse when a request is dropped
//   bottle_cnt  out  [15:0] confirmed bottles (DISPENSE_TALLY_EN only)
//   coin_cnt    out  [15:0] coins paid (DISPENSE_TALLY_EN only)
//   state_dbg   out  [2:0] current FSM state, for observation only
//
// Strobe semantics: vend_i and change_i carry no ready; each is accepted on
// every rising edge it is asserted. Requests that do not fit are discarded
// and reported through overflow, so the upstream FSM never stalls.
// -----------------------------------------------------------------------------
module vend_dispense_ctrl #(
    parameter int MOTOR_CYCLES      = 8,
    parameter int DROP_TIMEOUT      = 32,
    parameter int COIN_PULSE_CYCLES = 4,
    parameter int COIN_GAP_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vend_i,
    input  logic [1:0]  change_i,
    input  logic        drop_sense,
    input  logic        fault_clr,
    output logic        motor_on,
    output logic        coin_sol,
    output logic        busy,
    output logic        fault,
    output logic        overflow,
`ifdef DISPENSE_TALLY_EN
    output logic [15:0] bottle_cnt,
    output logic [15:0] coin_cnt,
`endif
    output logic [2:0]  state_dbg
);

    localparam int MAX_AB  = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
    localparam int MAX_CD  = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ? COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // The phase counter holds (cycles spent in the state - 1) at each edge,
    // so a phase ends when it reaches its length minus one.
    localparam logic [CNT_W-1:0] MOTOR_LAST = CNT_W'(MOTOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DROP_LAST  = CNT_W'(DROP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(COIN_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MOTOR     = 3'd1,
        S_WAIT_DROP = 3'd2,
        S_COIN_ON   = 3'd3,
        S_COIN_GAP  = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             drop_seen, drop_seen_nx;
    logic [1:0]       pend_b, pend_b_nx;
    logic [2:0]       pend_c, pend_c_nx;

    logic             take_b, take_c, clear_b;
    logic [2:0]       b_sum;
    logic [3:0]       c_sum;
    logic [1:0]       c_add;
    logic             b_clip, c_clip, ovf_nx;

    assign state_dbg = state;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt + 1'b1;
        drop_seen_nx = drop_seen;
        take_b       = 1'b0;
        take_c       = 1'b0;
        clear_b      = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                // Bottles are served before change.
                if (pend_b != 2'd0) begin
                    state_nx     = S_MOTOR;
                    take_b       = 1'b1;
                    drop_seen_nx = 1'b0;
                end else if (pend_c != 3'd0) begin
                    state_nx = S_COIN_ON;
                    take_c   = 1'b1;
                end
            end
            S_MOTOR: begin
                if (drop_sense) drop_seen_nx = 1'b1;
                if (cnt == MOTOR_LAST) begin
                    cnt_nx   = '0;
                    // A drop seen on the final motor cycle also counts.
                    state_nx = (drop_seen || drop_sense) ? S_IDLE : S_WAIT_DROP;
                end
            end
            S_WAIT_DROP: begin
                if (drop_sense) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DROP_LAST) begin
                    state_nx = S_FAULT;
                    cnt_nx   = '0;
                    clear_b  = 1'b1;
                end
            end
            S_COIN_ON: begin
                if (cnt == PULSE_LAST) begin
                    state_nx = S_COIN_GAP;
                    cnt_nx   = '0;
                end
            end
            S_COIN_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            S_FAULT: begin
                cnt_nx = '0;
                if (fault_clr) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Pending counters: capture and drain net out in the same cycle.
    // ---------------------------------------------------------------------
    always_comb begin
        c_add = 2'd0;
        case (change_i)
            2'b01:   c_add = 2'd1;
            2'b10:   c_add = 2'd2;
            default: c_add = 2'd0;
        endcase

        // take_b/take_c only assert with a non-zero count, so no underflow.
        b_sum  = {1'b0, pend_b} + {2'b00, vend_i} - {2'b00, take_b};
        c_sum  = {1'b0, pend_c} + {2'b00, c_add} - {3'b000, take_c};
        b_clip = (b_sum > 3'd3);
        c_clip = (c_sum > 4'd7);

        // Entering FAULT discards queued bottles; a vend arriving on that
        // same edge is discarded with them rather than reported as clipped.
        if (clear_b)     pend_b_nx = 2'd0;
        else if (b_clip) pend_b_nx = 2'd3;
        else             pend_b_nx = b_sum[1:0];

        pend_c_nx = c_clip ? 3'd7 : c_sum[2:0];

        ovf_nx = (b_clip && !clear_b) || c_clip || (change_i == 2'b11);
    end

    // ---------------------------------------------------------------------
    // State and registered outputs (outputs follow the next state so they
    // change on the same edge as the state they describe).
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            drop_seen <= 1'b0;
            pend_b    <= 2'd0;
            pend_c    <= 3'd0;
            motor_on  <= 1'b0;
            coin_sol  <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            drop_seen <= drop_seen_nx;
            pend_b    <= pend_b_nx;
            pend_c    <= pend_c_nx;
            motor_on  <= (state_nx == S_MOTOR);
            coin_sol  <= (state_nx == S_COIN_ON);
            fault     <= (state_nx == S_FAULT);
            busy      <= (state_nx != S_IDLE) || (pend_b_nx != 2'd0) || (pend_c_nx != 3'd0);
            overflow  <= ovf_nx;
        end
    end

`ifdef DISPENSE_TALLY_EN
    // A bottle is confirmed when the motor/drop phase returns to IDLE; the
    // only other exit from that phase is FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bottle_cnt <= 16'd0;
            coin_cnt   <= 16'd0;
        end else begin
            if ((state == S_MOTOR || state == S_WAIT_DROP) && state_nx == S_IDLE)
                bottle_cnt <= bottle_cnt + 16'd1;
            if (state == S_COIN_ON && state_nx == S_COIN_GAP)
                coin_cnt <= coin_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_dispense_ctrl
//
// Bench for vend_dispense_ctrl with default parameters. Each job issues a
// vend (plus optional queued vends and change codes) while the block is idle.
// The expected actuator activity is derived from the job description alone:
// number of motor runs after pend_b saturation, where a jam stops the bottle
// sequence, how many coins survive pend_c saturation, and how many cycles
// clip. The expected pulses go into exp_q; a monitor measures every motor,
// coin and fault event on the outputs and pops/compares them in order.
// A sensor process plays the drop-sensor timing planned for each motor run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vend_dispense_ctrl;

    localparam int MOTOR_CYCLES      = 8;
    localparam int DROP_TIMEOUT      = 32;
    localparam int COIN_PULSE_CYCLES = 4;
    localparam int COIN_GAP_CYCLES   = 2;
    localparam int W                 = 16;
    localparam int LIMIT             = 3000;

    localparam logic [3:0] K_MOTOR = 4'd1;
    localparam logic [3:0] K_COIN  = 4'd2;
    localparam logic [3:0] K_FAULT = 4'd3;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       vend_i     = 1'b0;
    logic [1:0] change_i   = 2'b00;
    logic       drop_sense = 1'b0;
    logic       fault_clr  = 1'b0;
    logic       motor_on, coin_sol, busy, fault, overflow;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    vend_dispense_ctrl #(
        .MOTOR_CYCLES      (MOTOR_CYCLES),
        .DROP_TIMEOUT      (DROP_TIMEOUT),
        .COIN_PULSE_CYCLES (COIN_PULSE_CYCLES),
        .COIN_GAP_CYCLES   (COIN_GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vend_i     (vend_i),
        .change_i   (change_i),
        .drop_sense (drop_sense),
        .fault_clr  (fault_clr),
        .motor_on   (motor_on),
        .coin_sol   (coin_sol),
        .busy       (busy),
        .fault      (fault),
        .overflow   (overflow),
        .state_dbg  (state_dbg)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int          errors  = 0;
    int          checks  = 0;
    logic [W-1:0] exp_q[$];
    int          plan_q[$];
    int          ov_seen = 0;
    bit          mon_en  = 1'b0;

    // Job description filled in before run_job
    int          job_extra;
    logic [1:0]  job_chg[5];
    int          job_plan[4];
    bit          job_fault_chg;
    bit          job_clr_early;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_event(input string name, input logic [3:0] kind, input int width);
        logic [W-1:0] got;
        logic [W-1:0] want;
        got = {kind, 12'(width)};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event kind %0d width %0d, none expected", name, kind, width);
        end else begin
            want = exp_q.pop_front();
            check(name, {16'd0, got}, {16'd0, want});
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Monitor: measures pulses on the outputs and compares to exp_q
    // ------------------------------------------------------------------
    int   m_run = 0;
    int   c_run = 0;
    int   c_gap = 0;
    bit   c_any = 1'b0;
    logic f_prev = 1'b0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                m_run  = 0;
                c_run  = 0;
                c_gap  = 0;
                c_any  = 1'b0;
                f_prev = fault;
            end else begin
                if (motor_on) begin
                    m_run++;
                end else if (m_run != 0) begin
                    expect_event("motor_pulse", K_MOTOR, m_run);
                    m_run = 0;
                end
                if (coin_sol) begin
                    if (c_run == 0 && c_any)
                        check("coin_gap_min", (c_gap >= COIN_GAP_CYCLES) ? 32'd1 : 32'd0, 32'd1);
                    c_run++;
                end else begin
                    if (c_run != 0) begin
                        expect_event("coin_pulse", K_COIN, c_run);
                        c_run = 0;
                        c_gap = 0;
                        c_any = 1'b1;
                    end
                    c_gap++;
                end
                if (fault && !f_prev) expect_event("fault_rise", K_FAULT, 0);
                f_prev = fault;
                if (overflow) ov_seen++;
                if (motor_on && coin_sol) check("actuator_exclusive", {31'd0, coin_sol}, 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Drop sensor: for each motor run, pulse drop_sense at the planned
    // negedge counted from the first motor cycle (-1 = jam, no pulse).
    // ------------------------------------------------------------------
    initial begin : sensor
        bit prev;
        int plan;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (motor_on && !prev) begin
                    plan = (plan_q.size() == 0) ? -1 : plan_q.pop_front();
                    if (plan >= 0) begin
                        repeat (plan) @(negedge clk);
                        drop_sense = 1'b1;
                        @(negedge clk);
                        drop_sense = 1'b0;
                    end
                end
                prev = motor_on;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < LIMIT) begin
            tick();
            n++;
        end
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL %s: busy still %0d after %0d cycles, expected 0", name, busy, n);
        end
    endtask

    function automatic int coin_val(input logic [1:0] code);
        return (code == 2'b01) ? 1 : (code == 2'b10) ? 2 : 0;
    endfunction

    task automatic run_job(input string tag);
        int runs, c, add, queued_b, exp_ov, n;
        bit jam, clip_b, clip_c;

        ov_seen = 0;

        // Reference: the first vend starts the motor at once; later vends
        // queue up to three; change accumulates up to seven coins.
        runs     = 1 + ((job_extra > 3) ? 3 : job_extra);
        c        = 0;
        queued_b = 0;
        exp_ov   = 0;
        for (int k = 0; k <= job_extra; k++) begin
            add    = coin_val(job_chg[k]);
            clip_c = (c + add > 7);
            c      = (c + add > 7) ? 7 : c + add;
            clip_b = 1'b0;
            if (k > 0) begin
                if (queued_b == 3) clip_b = 1'b1;
                else queued_b++;
            end
            if (clip_b || clip_c || job_chg[k] == 2'b11) exp_ov++;
        end
        jam = 1'b0;
        for (int b = 0; b < runs; b++) begin
            exp_q.push_back({K_MOTOR, 12'(MOTOR_CYCLES)});
            plan_q.push_back(job_plan[b]);
            if (job_plan[b] < 0) begin
                jam = 1'b1;
                exp_q.push_back({K_FAULT, 12'd0});
                break;
            end
        end
        if (jam && job_fault_chg) begin
            if (c == 7) exp_ov++;
            else c++;
        end
        for (int i = 0; i < c; i++) exp_q.push_back({K_COIN, 12'(COIN_PULSE_CYCLES)});

        // Stimulus
        vend_i   = 1'b1;
        change_i = job_chg[0];
        tick();
        vend_i   = 1'b0;
        change_i = 2'b00;
        check({tag, "_motor_not_yet"}, {31'd0, motor_on}, 32'd0);
        tick();
        check({tag, "_motor_start"}, {31'd0, motor_on}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            vend_i    = (k <= job_extra);
            change_i  = (k <= job_extra) ? job_chg[k] : 2'b00;
            fault_clr = (k == 1) ? job_clr_early : 1'b0;
            tick();
        end
        vend_i    = 1'b0;
        change_i  = 2'b00;
        fault_clr = 1'b0;

        if (jam) begin
            n = 0;
            while (!fault && n < LIMIT) begin
                tick();
                n++;
            end
            checks++;
            if (n >= LIMIT) begin
                errors++;
                $display("FAIL %s_fault_wait: fault %0d after %0d cycles, expected 1", tag, fault, n);
            end
            tick();
            if (job_fault_chg) begin
                change_i = 2'b01;
                tick();
                change_i = 2'b00;
            end
            repeat (2) tick();
            check({tag, "_fault_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_fault_motor_off"}, {31'd0, motor_on}, 32'd0);
            check({tag, "_fault_coin_off"}, {31'd0, coin_sol}, 32'd0);
            fault_clr = 1'b1;
            tick();
            fault_clr = 1'b0;
            check({tag, "_fault_cleared"}, {31'd0, fault}, 32'd0);
        end

        wait_idle({tag, "_idle"});
        repeat (3) tick();
        check({tag, "_events_left"}, exp_q.size(), 32'd0);
        check({tag, "_overflow_count"}, ov_seen, exp_ov);
        check({tag, "_fault_end"}, {31'd0, fault}, 32'd0);
        check({tag, "_plans_left"}, plan_q.size(), 32'd0);
        exp_q.delete();
        plan_q.delete();
    endtask

    task automatic clear_job();
        job_extra     = 0;
        job_fault_chg = 1'b0;
        job_clr_early = 1'b0;
        for (int i = 0; i < 5; i++) job_chg[i] = 2'b00;
        for (int i = 0; i < 4; i++) job_plan[i] = 3;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        int r, n_hi;

        repeat (3) tick();
        check("reset_motor_on", {31'd0, motor_on}, 32'd0);
        check("reset_coin_sol", {31'd0, coin_sol}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_fault", {31'd0, fault}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) tick();

        // Single vend, drop at motor cycle 3
        clear_job();
        run_job("single");

        // Vend with two coins in the same cycle
        clear_job();
        job_chg[0]  = 2'b10;
        job_plan[0] = 2;
        run_job("vend_change");

        // Jam, then one coin requested while faulted
        clear_job();
        job_plan[0]   = -1;
        job_fault_chg = 1'b1;
        run_job("jam");

        // Bottle and change saturation: 1 + 4 vends, 10 coins requested
        clear_job();
        job_extra = 4;
        for (int i = 0; i < 5; i++) job_chg[i] = 2'b10;
        job_plan[1] = 12;
        job_plan[2] = 0;
        job_plan[3] = 7;
        run_job("saturate");

        // Invalid change code while idle
        ov_seen  = 0;
        change_i = 2'b11;
        tick();
        change_i = 2'b00;
        repeat (4) tick();
        check("invalid_overflow", ov_seen, 32'd1);
        check("invalid_busy", {31'd0, busy}, 32'd0);
        check("invalid_no_events", exp_q.size(), 32'd0);

        // fault_clr while idle has no effect
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        repeat (2) tick();
        check("stray_clr_fault", {31'd0, fault}, 32'd0);
        check("stray_clr_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a coin pulse with pend_c = 3 queued behind it
        mon_en   = 1'b0;
        change_i = 2'b10;
        tick();
        change_i = 2'b10;
        tick();
        change_i = 2'b00;
        check("rst_coin_started", {31'd0, coin_sol}, 32'd1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_coin_drop", {31'd0, coin_sol}, 32'd0);
        check("rst_busy_drop", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_hi  = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (coin_sol || motor_on) n_hi++;
        end
        check("rst_no_more_pulses", n_hi, 32'd0);
        check("rst_idle_busy", {31'd0, busy}, 32'd0);
        mon_en = 1'b1;
        tick();

        // Randomized jobs
        for (int j = 0; j < 25; j++) begin
            clear_job();
            job_extra     = $urandom_range(0, 4);
            job_chg[0]    = 2'($urandom_range(0, 3));
            for (int k = 1; k < 5; k++) job_chg[k] = 2'($urandom_range(0, 2));
            for (int b = 0; b < 4; b++) begin
                r = $urandom_range(0, 9);
                if (r < 6)      job_plan[b] = $urandom_range(0, 7);
                else if (r < 9) job_plan[b] = $urandom_range(8, 30);
                else            job_plan[b] = -1;
            end
            job_fault_chg = 1'($urandom_range(0, 1));
            job_clr_early = 1'($urandom_range(0, 1));
            run_job($sformatf("rand%0d", j));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, expected to be done", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
